ddr3_app_adapter: RTL and testbench

- Parametrised request/response front end for the MIG 7-series DDR3 user (app_*) interface; it runs entirely in the MIG ui_clk domain.
- Accepts tagged read/write requests on a valid/ready stream and drives app_en/app_cmd/app_addr and the write-data FIFO independently.
- Tracks outstanding reads with a tag FIFO and returns read data with its tag on a backpressurable response stream.
- Credit-limits reads so that unstallable MIG read data can never overflow the response buffer.

---
 rtl/ddr3_adapter_pkg.sv | 18 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/ddr3_app_adapter.sv | 201 ++++++++++++++++++++
 tb/tb_ddr3_app_adapter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_adapter_pkg.sv
// Shared constants, FSM state type and sizing helper for the DDR3 app adapter.
package ddr3_adapter_pkg;

   localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
   localparam logic [2:0] MIG_CMD_READ  = 3'b001;

   typedef enum logic [1:0] {
      ST_CALIB = 2'd0,
      ST_IDLE  = 2'd1,
      ST_ISSUE = 2'd2
   } adapter_state_t;

   // Bits needed to hold a credit count in the range 0..max_out.
   function automatic int credit_width(input int max_out);
      return $clog2(max_out + 1);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, first-word fall-through, push accepted on full when popping.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_pop;
   logic             w_do_push;

   assign o_full    = (r_count == FULL_CNT);
   assign o_empty   = (r_count == '0);
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_rdata   = r_mem[r_rd_ptr];

   // Storage array; contents need no reset, occupancy is tracked separately.
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ddr3_app_adapter.sv
// Tagged request/response front end for the MIG 7-series DDR3 app interface.
module ddr3_app_adapter
   import ddr3_adapter_pkg::*;
#(
   parameter int ADDR_WIDTH      = 29,
   parameter int MIG_ADDR_WIDTH  = 28,
   parameter int DATA_WIDTH      = 256,
   parameter int TAG_WIDTH       = 4,
   parameter int MAX_OUTSTANDING = 16
) (
   input  logic                                     ui_clk,
   input  logic                                     ui_clk_sync_rst,
   input  logic                                     init_calib_complete,
   input  logic                                     req_valid,
   output logic                                     req_ready,
   input  logic                                     req_write,
   input  logic [ADDR_WIDTH-1:0]                    req_addr,
   input  logic [TAG_WIDTH-1:0]                     req_tag,
   input  logic [DATA_WIDTH-1:0]                    req_wdata,
   input  logic [DATA_WIDTH/8-1:0]                  req_wbe,
   output logic                                     rsp_valid,
   input  logic                                     rsp_ready,
   output logic [TAG_WIDTH-1:0]                     rsp_tag,
   output logic [DATA_WIDTH-1:0]                    rsp_data,
   output logic [MIG_ADDR_WIDTH-1:0]                app_addr,
   output logic [2:0]                               app_cmd,
   output logic                                     app_en,
   input  logic                                     app_rdy,
   output logic [DATA_WIDTH-1:0]                    app_wdf_data,
   output logic [DATA_WIDTH/8-1:0]                  app_wdf_mask,
   output logic                                     app_wdf_wren,
   output logic                                     app_wdf_end,
   input  logic                                     app_wdf_rdy,
   input  logic [DATA_WIDTH-1:0]                    app_rd_data,
   input  logic                                     app_rd_data_valid,
   input  logic                                     app_rd_data_end,
   output logic [credit_width(MAX_OUTSTANDING)-1:0] outstanding,
   output logic                                     err_addr,
   output logic                                     err_proto
);

   localparam int CW    = credit_width(MAX_OUTSTANDING);
   localparam int RSP_W = TAG_WIDTH + DATA_WIDTH;
   localparam logic [CW-1:0] CREDITS_MAX = CW'(MAX_OUTSTANDING);

   adapter_state_t          r_state;
   adapter_state_t          w_state_next;
   logic [MIG_ADDR_WIDTH-1:0] r_addr;
   logic [2:0]              r_cmd;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [DATA_WIDTH/8-1:0] r_mask;
   logic [TAG_WIDTH-1:0]    r_tag;
   logic                    r_cmd_done;
   logic                    r_wdf_done;
   logic [CW-1:0]           r_credits;
   logic                    r_err_addr;
   logic                    r_err_proto;

   logic                    w_is_write;
   logic                    w_req_fire;
   logic                    w_cmd_fire;
   logic                    w_wdf_fire;
   logic                    w_rd_accept;
   logic                    w_rsp_pop;
   logic                    w_addr_hi;
   logic [TAG_WIDTH-1:0]    w_tag_rdata;
   logic                    w_tag_full;
   logic                    w_tag_empty;
   logic                    w_rsp_push;
   logic [RSP_W-1:0]        w_rsp_rdata;
   logic                    w_rsp_full;
   logic                    w_rsp_empty;
   logic                    w_proto_err;
   logic                    w_unused;

   if (ADDR_WIDTH > MIG_ADDR_WIDTH) begin : g_addr_hi
      assign w_addr_hi = |req_addr[ADDR_WIDTH-1:MIG_ADDR_WIDTH];
   end else begin : g_no_addr_hi
      assign w_addr_hi = 1'b0;
   end

   assign w_is_write  = (r_cmd == MIG_CMD_WRITE);
   assign w_req_fire  = req_valid && req_ready;
   assign w_cmd_fire  = app_en && app_rdy;
   assign w_wdf_fire  = app_wdf_wren && app_wdf_rdy;
   assign w_rd_accept = w_cmd_fire && !w_is_write;
   assign w_rsp_pop   = rsp_valid && rsp_ready;
   assign w_rsp_push  = app_rd_data_valid && !w_tag_empty;
   assign w_proto_err = (app_rd_data_valid && w_tag_empty) ||
                        (w_rsp_push && w_rsp_full && !w_rsp_pop);
   assign w_unused    = &{app_rd_data_end, w_tag_full};

   assign app_addr     = r_addr;
   assign app_cmd      = r_cmd;
   assign app_wdf_data = r_wdata;
   assign app_wdf_mask = r_mask;
   assign app_wdf_end  = app_wdf_wren;
   assign outstanding  = CREDITS_MAX - r_credits;
   assign err_addr     = r_err_addr;
   assign err_proto    = r_err_proto;
   assign rsp_valid    = !w_rsp_empty;
   // Gate the FWFT head so stale storage never leaks out while empty.
   assign {rsp_tag, rsp_data} = w_rsp_empty ? '0 : w_rsp_rdata;

   // FSM state register.
   always_ff @(posedge ui_clk) begin
      if (ui_clk_sync_rst) r_state <= ST_CALIB;
      else                 r_state <= w_state_next;
   end

   // Next-state and handshake outputs; command and write-data lanes finish independently.
   always_comb begin
      w_state_next = r_state;
      req_ready    = 1'b0;
      app_en       = 1'b0;
      app_wdf_wren = 1'b0;
      case (r_state)
         ST_CALIB: begin
            if (init_calib_complete) w_state_next = ST_IDLE;
         end
         ST_IDLE: begin
            req_ready = req_write || (r_credits != '0);
            if (req_valid && req_ready) w_state_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            app_en       = !r_cmd_done;
            app_wdf_wren = w_is_write && !r_wdf_done;
            if ((r_cmd_done || app_rdy) &&
                (!w_is_write || r_wdf_done || app_wdf_rdy)) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_CALIB;
      endcase
   end

   // Request capture, lane completion, read credits and sticky error flags.
   always_ff @(posedge ui_clk) begin
      if (ui_clk_sync_rst) begin
         r_addr      <= '0;
         r_cmd       <= '0;
         r_wdata     <= '0;
         r_mask      <= '0;
         r_tag       <= '0;
         r_cmd_done  <= 1'b0;
         r_wdf_done  <= 1'b0;
         r_credits   <= CREDITS_MAX;
         r_err_addr  <= 1'b0;
         r_err_proto <= 1'b0;
      end else begin
         if (w_req_fire) begin
            r_addr     <= req_addr[MIG_ADDR_WIDTH-1:0];
            r_cmd      <= req_write ? MIG_CMD_WRITE : MIG_CMD_READ;
            r_wdata    <= req_wdata;
            r_mask     <= ~req_wbe;
            r_tag      <= req_tag;
            r_cmd_done <= 1'b0;
            r_wdf_done <= 1'b0;
         end else begin
            if (w_cmd_fire) r_cmd_done <= 1'b1;
            if (w_wdf_fire) r_wdf_done <= 1'b1;
         end
         if (w_req_fire && w_addr_hi) r_err_addr  <= 1'b1;
         if (w_proto_err)             r_err_proto <= 1'b1;
         case ({w_rd_accept, w_rsp_pop})
            2'b10:   r_credits <= r_credits - 1'b1;
            2'b01:   r_credits <= r_credits + 1'b1;
            default: r_credits <= r_credits;
         endcase
      end
   end

   sync_fifo #(
      .WIDTH (TAG_WIDTH),
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .i_clk   (ui_clk),
      .i_rst   (ui_clk_sync_rst),
      .i_push  (w_rd_accept),
      .i_wdata (r_tag),
      .i_pop   (app_rd_data_valid),
      .o_rdata (w_tag_rdata),
      .o_full  (w_tag_full),
      .o_empty (w_tag_empty)
   );

   sync_fifo #(
      .WIDTH (RSP_W),
      .DEPTH (MAX_OUTSTANDING)
   ) u_rsp_fifo (
      .i_clk   (ui_clk),
      .i_rst   (ui_clk_sync_rst),
      .i_push  (w_rsp_push),
      .i_wdata ({w_tag_rdata, app_rd_data}),
      .i_pop   (w_rsp_pop),
      .o_rdata (w_rsp_rdata),
      .o_full  (w_rsp_full),
      .o_empty (w_rsp_empty)
   );

endmodule

// File: tb/tb_ddr3_app_adapter.sv
// Scoreboard bench for ddr3_app_adapter with a behavioural MIG read-return model.
module tb_ddr3_app_adapter;

   logic         ui_clk = 1'b0;
   logic         ui_clk_sync_rst;
   logic         init_calib_complete;
   logic         req_valid;
   logic         req_ready;
   logic         req_write;
   logic [28:0]  req_addr;
   logic [3:0]   req_tag;
   logic [255:0] req_wdata;
   logic [31:0]  req_wbe;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [3:0]   rsp_tag;
   logic [255:0] rsp_data;
   logic [27:0]  app_addr;
   logic [2:0]   app_cmd;
   logic         app_en;
   logic         app_rdy;
   logic [255:0] app_wdf_data;
   logic [31:0]  app_wdf_mask;
   logic         app_wdf_wren;
   logic         app_wdf_end;
   logic         app_wdf_rdy;
   logic [255:0] app_rd_data;
   logic         app_rd_data_valid;
   logic         app_rd_data_end;
   logic [4:0]   outstanding;
   logic         err_addr;
   logic         err_proto;

   int           n_tests;
   int           n_fail;
   logic [259:0] exp_q [$];
   int           exp_rd;
   logic [27:0]  mq [$];
   logic         ret_en;
   int           inj_req;
   int           inj_done;

   localparam logic [255:0] WD  = {8{32'hC0DE_1234}};
   localparam logic [255:0] WD2 = {8{32'h0BAD_F00D}};

   ddr3_app_adapter #(
      .ADDR_WIDTH      (29),
      .MIG_ADDR_WIDTH  (28),
      .DATA_WIDTH      (256),
      .TAG_WIDTH       (4),
      .MAX_OUTSTANDING (16)
   ) dut (
      .ui_clk              (ui_clk),
      .ui_clk_sync_rst     (ui_clk_sync_rst),
      .init_calib_complete (init_calib_complete),
      .req_valid           (req_valid),
      .req_ready           (req_ready),
      .req_write           (req_write),
      .req_addr            (req_addr),
      .req_tag             (req_tag),
      .req_wdata           (req_wdata),
      .req_wbe             (req_wbe),
      .rsp_valid           (rsp_valid),
      .rsp_ready           (rsp_ready),
      .rsp_tag             (rsp_tag),
      .rsp_data            (rsp_data),
      .app_addr            (app_addr),
      .app_cmd             (app_cmd),
      .app_en              (app_en),
      .app_rdy             (app_rdy),
      .app_wdf_data        (app_wdf_data),
      .app_wdf_mask        (app_wdf_mask),
      .app_wdf_wren        (app_wdf_wren),
      .app_wdf_end         (app_wdf_end),
      .app_wdf_rdy         (app_wdf_rdy),
      .app_rd_data         (app_rd_data),
      .app_rd_data_valid   (app_rd_data_valid),
      .app_rd_data_end     (app_rd_data_end),
      .outstanding         (outstanding),
      .err_addr            (err_addr),
      .err_proto           (err_proto)
   );

   always #5 ui_clk = ~ui_clk;

   function automatic logic [255:0] mdata(input logic [27:0] a);
      return {8{{4'h0, a} ^ 32'h5A5A_0000}};
   endfunction

   task automatic check_eq(input string nm, input logic [279:0] obs, input logic [279:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, obs, exp);
      end
   endtask

   task automatic adv();
      @(posedge ui_clk);
      #1;
   endtask

   task automatic check_zero(input string nm);
      check_eq({nm, "_ctl"}, {req_ready, app_en, app_wdf_wren, app_wdf_end,
                              rsp_valid, err_addr, err_proto}, '0);
      check_eq({nm, "_addr"}, app_addr, '0);
      check_eq({nm, "_cmd"}, app_cmd, '0);
      check_eq({nm, "_outst"}, outstanding, '0);
      check_eq({nm, "_mask"}, app_wdf_mask, '0);
      check_eq({nm, "_wdata"}, app_wdf_data, '0);
      check_eq({nm, "_rsp"}, {rsp_tag, rsp_data}, '0);
   endtask

   // Called at a drive point; returns at the drive point of the cycle after the handshake.
   task automatic send_req(input bit wr, input logic [28:0] addr, input logic [3:0] tag,
                           input logic [255:0] wd, input logic [31:0] wbe, output bit ok);
      ok        = 1'b0;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_tag   = tag;
      req_wdata = wd;
      req_wbe   = wbe;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(negedge ui_clk);
         if (req_ready) begin
            ok = 1'b1;
            if (!wr) exp_q.push_back({tag, mdata(addr[27:0])});
         end
         adv();
      end
      req_valid = 1'b0;
   endtask

   task automatic wait_drain(input string nm);
      for (int i = 0; i < 300; i++) begin
         adv();
         @(negedge ui_clk);
         if (exp_rd == exp_q.size() && outstanding == 5'd0) break;
      end
      check_eq({nm, "_outst"}, outstanding, 5'd0);
      check_eq({nm, "_pending"}, exp_q.size() - exp_rd, 0);
      adv();
   endtask

   // MIG model: capture read commands, return data in order; response scoreboard.
   always begin
      @(negedge ui_clk);
      if (ui_clk_sync_rst) begin
         mq.delete();
      end else begin
         if (app_en && app_rdy && app_cmd == 3'b001) mq.push_back(app_addr);
         if (rsp_valid && rsp_ready) begin
            if (exp_rd >= exp_q.size()) begin
               check_eq("rsp_unexpected", rsp_valid, 1'b0);
            end else begin
               check_eq("rsp", {rsp_tag, rsp_data}, exp_q[exp_rd]);
               exp_rd++;
            end
         end
      end
      @(posedge ui_clk);
      #2;
      if (inj_req != inj_done) begin
         inj_done          = inj_req;
         app_rd_data_valid = 1'b1;
         app_rd_data       = {8{32'hDEAD_BEEF}};
      end else if (ret_en && mq.size() > 0) begin
         app_rd_data_valid = 1'b1;
         app_rd_data       = mdata(mq.pop_front());
      end else begin
         app_rd_data_valid = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      int stall;
      bit ok;
      n_tests             = 0;
      n_fail              = 0;
      exp_rd              = 0;
      inj_req             = 0;
      inj_done            = 0;
      ret_en              = 1'b0;
      ui_clk_sync_rst     = 1'b1;
      init_calib_complete = 1'b0;
      req_valid           = 1'b0;
      req_write           = 1'b0;
      req_addr            = '0;
      req_tag             = '0;
      req_wdata           = '0;
      req_wbe             = '0;
      rsp_ready           = 1'b0;
      app_rdy             = 1'b1;
      app_wdf_rdy         = 1'b0;
      app_rd_data         = '0;
      app_rd_data_valid   = 1'b0;
      app_rd_data_end     = 1'b0;

      repeat (3) adv();
      @(negedge ui_clk);
      check_zero("reset");

      // Calibration hold with a write request already pending.
      adv();
      ui_clk_sync_rst = 1'b0;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 29'h100;
      req_wbe   = 32'hFFFF_0000;
      req_wdata = WD;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge ui_clk);
         if (req_ready || app_en) bad++;
         adv();
      end
      check_eq("calib_hold", bad, 0);
      init_calib_complete = 1'b1;
      @(negedge ui_clk);
      check_eq("calib_edge_ready", req_ready, 1'b0);
      adv();
      @(negedge ui_clk);
      check_eq("calib_done_ready", req_ready, 1'b1);
      adv();
      req_valid = 1'b0;

      // Write: command lane completes at once, data lane held 5 cycles.
      for (int i = 0; i < 5; i++) begin
         @(negedge ui_clk);
         check_eq("wr_app_en", app_en, (i == 0));
         check_eq("wr_wren_end", {app_wdf_wren, app_wdf_end}, 2'b11);
         check_eq("wr_data", app_wdf_data, WD);
         check_eq("wr_mask", app_wdf_mask, 32'h0000_FFFF);
         check_eq("wr_addr_cmd", {app_addr, app_cmd}, {28'h100, 3'b000});
         adv();
      end
      app_wdf_rdy = 1'b1;
      @(negedge ui_clk);
      check_eq("wr_wren_last", app_wdf_wren, 1'b1);
      adv();
      @(negedge ui_clk);
      check_eq("wr_done", {app_wdf_wren, app_en, req_ready}, 3'b001);
      adv();

      // Credit exhaustion: 16 reads with the consumer stalled.
      ret_en = 1'b1;
      for (int t = 0; t < 16; t++) begin
         send_req(1'b0, 29'(32'h200 + 8 * t), 4'(t), '0, '0, ok);
         check_eq("rd_accept", ok, 1'b1);
      end
      req_valid = 1'b1;
      req_write = 1'b0;
      req_tag   = 4'hA;
      req_addr  = 29'h400;
      stall = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge ui_clk);
         if (req_ready) stall++;
         adv();
      end
      check_eq("rd17_stall", stall, 0);
      @(negedge ui_clk);
      check_eq("rd_full_outst", outstanding, 5'd16);
      check_eq("rd_full_rsp_valid", rsp_valid, 1'b1);
      adv();
      rsp_ready = 1'b1;
      @(negedge ui_clk);
      check_eq("rd_pop_ready", req_ready, 1'b0);
      adv();
      rsp_ready = 1'b0;
      @(negedge ui_clk);
      check_eq("rd17_ready", req_ready, 1'b1);
      check_eq("rd17_outst", outstanding, 5'd15);
      if (req_ready) exp_q.push_back({4'hA, mdata(28'h400)});
      adv();
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      wait_drain("drain16");

      // Two reads with delayed return; order and tags via scoreboard.
      ret_en = 1'b0;
      send_req(1'b0, 29'h300, 4'd3, '0, '0, ok);
      check_eq("rdA_accept", ok, 1'b1);
      send_req(1'b0, 29'h340, 4'd9, '0, '0, ok);
      check_eq("rdB_accept", ok, 1'b1);
      repeat (4) adv();
      @(negedge ui_clk);
      check_eq("ab_wait_outst", outstanding, 5'd2);
      check_eq("ab_wait_rsp", rsp_valid, 1'b0);
      adv();
      ret_en = 1'b1;
      wait_drain("drainAB");

      // Out-of-range address: truncated, sticky error.
      @(negedge ui_clk);
      check_eq("err_addr_pre", err_addr, 1'b0);
      adv();
      send_req(1'b1, 29'h1000_0040, 4'd0, WD2, 32'hFFFF_FFFF, ok);
      check_eq("hi_accept", ok, 1'b1);
      @(negedge ui_clk);
      check_eq("hi_app_addr", app_addr, 28'h000_0040);
      check_eq("hi_err_addr", err_addr, 1'b1);
      adv();
      adv();

      // Stray read data with nothing outstanding.
      @(negedge ui_clk);
      check_eq("err_proto_pre", err_proto, 1'b0);
      adv();
      inj_req++;
      adv();
      @(negedge ui_clk);
      check_eq("stray_err_proto", err_proto, 1'b1);
      check_eq("stray_no_rsp", rsp_valid, 1'b0);
      check_eq("stray_outst", outstanding, 5'd0);
      adv();
      @(negedge ui_clk);
      check_eq("err_addr_sticky", err_addr, 1'b1);
      adv();

      // Reset while both lanes are stalled in ISSUE.
      app_rdy     = 1'b0;
      app_wdf_rdy = 1'b0;
      send_req(1'b1, 29'h80, 4'd0, WD, 32'hFFFF_FFFF, ok);
      check_eq("stuck_accept", ok, 1'b1);
      @(negedge ui_clk);
      check_eq("stuck_issue", {app_en, app_wdf_wren}, 2'b11);
      adv();
      ui_clk_sync_rst = 1'b1;
      adv();
      ui_clk_sync_rst = 1'b0;
      @(negedge ui_clk);
      check_zero("midrst");
      adv();
      @(negedge ui_clk);
      check_eq("ready_after_rst", req_ready, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
